// File: rtl/demux_dispatch_pkg.sv
// demux_dispatch_pkg: shared constants and state encoding for the demux dispatcher
package demux_dispatch_pkg;
  localparam int CH_N = 4;
  localparam int SEL_W = 2;
  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;
  localparam logic [SEL_W-1:0] PTR_RST = 2'd3;
endpackage

// File: rtl/demux_1to4.sv
// demux_1to4: routes d onto the lane chosen by sel, other lanes read zero
module demux_1to4 #(
  parameter int W = 4
) (
  input  logic [W-1:0] d,
  input  logic [1:0]   sel,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3
);
  assign y0 = (sel == 2'd0) ? d : '0;
  assign y1 = (sel == 2'd1) ? d : '0;
  assign y2 = (sel == 2'd2) ? d : '0;
  assign y3 = (sel == 2'd3) ? d : '0;
endmodule

// File: rtl/demux_rr_pick.sv
// demux_rr_pick: first enabled channel after ptr, wrapping back to ptr itself last
module demux_rr_pick
  import demux_dispatch_pkg::*;
(
  input  logic [SEL_W-1:0] ptr,
  input  logic [CH_N-1:0]  en,
  output logic [SEL_W-1:0] pick,
  output logic             any_en
);
  logic [SEL_W-1:0] w_p1, w_p2, w_p3;
  assign w_p1 = ptr + 2'd1;
  assign w_p2 = ptr + 2'd2;
  assign w_p3 = ptr + 2'd3;
  assign any_en = |en;
  assign pick = en[w_p1] ? w_p1 : en[w_p2] ? w_p2 : en[w_p3] ? w_p3 : ptr;
endmodule

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: one-entry round-robin dispatcher onto 4 lanes; DEMUX_DISPATCH_CNT_EN adds saturating per-lane delivery counters
module demux_dispatcher
  import demux_dispatch_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_N-1:0]   ch_en,
  output logic [CH_N-1:0]   out_valid,
  input  logic [CH_N-1:0]   out_ready,
  output logic [DATA_W-1:0] y0,
  output logic [DATA_W-1:0] y1,
  output logic [DATA_W-1:0] y2,
  output logic [DATA_W-1:0] y3,
  output logic [SEL_W-1:0]  sel,
  output logic              busy
`ifdef DEMUX_DISPATCH_CNT_EN
  ,
  output logic [CH_N*CNT_W-1:0] cnt_flat
`endif
);
  state_t r_state, w_state_nxt;
  logic [SEL_W-1:0] r_tgt, r_ptr, w_pick;
  logic [DATA_W-1:0] r_data, w_d0, w_d1, w_d2, w_d3;
  logic w_any_en, w_full, w_acc, w_xfer;

  assign w_full = (r_state == ST_FULL);
  assign in_ready = ~rst & w_any_en & (~w_full | out_ready[r_tgt]);
  assign w_acc = in_valid & in_ready;
  assign w_xfer = w_full & out_ready[r_tgt];

  demux_rr_pick u_pick (
    .ptr(r_ptr),
    .en(ch_en),
    .pick(w_pick),
    .any_en(w_any_en)
  );

  // state register
  always_ff @(posedge clk)
    if (rst) r_state <= ST_EMPTY;
    else r_state <= w_state_nxt;

  // a new word always fills the buffer; a lone transfer empties it
  always_comb w_state_nxt = w_acc ? ST_FULL : (w_xfer ? ST_EMPTY : r_state);

  // capture word and its target on accept; target stays fixed until replaced
  always_ff @(posedge clk)
    if (rst) begin
      r_tgt  <= '0;
      r_ptr  <= PTR_RST;
      r_data <= '0;
    end else if (w_acc) begin
      r_tgt  <= w_pick;
      r_ptr  <= w_pick;
      r_data <= in_data;
    end

  demux_1to4 #(.W(DATA_W)) u_demux (
    .d(r_data),
    .sel(r_tgt),
    .y0(w_d0),
    .y1(w_d1),
    .y2(w_d2),
    .y3(w_d3)
  );

  assign y0 = w_full ? w_d0 : '0;
  assign y1 = w_full ? w_d1 : '0;
  assign y2 = w_full ? w_d2 : '0;
  assign y3 = w_full ? w_d3 : '0;
  assign out_valid = {3'b000, w_full} << r_tgt;
  assign sel = r_tgt;
  assign busy = w_full;

`ifdef DEMUX_DISPATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt [CH_N];
  for (genvar i = 0; i < CH_N; i++) begin : g_cnt
    // count deliveries on this lane, holding at all-ones
    always_ff @(posedge clk)
      if (rst) r_cnt[i] <= '0;
      else if (w_xfer && r_tgt == SEL_W'(i) && !(&r_cnt[i])) r_cnt[i] <= r_cnt[i] + 1'b1;
    assign cnt_flat[i*CNT_W +: CNT_W] = r_cnt[i];
  end
`endif
endmodule

// File: tb/tb_demux_dispatcher.sv
// tb_demux_dispatcher: directed plus random checks against a transaction-level model
module tb_demux_dispatcher;
  localparam int DW = 4;
`ifdef DEMUX_DISPATCH_CNT_EN
  localparam int CW = 2;
`else
  localparam int CW = 8;
`endif
  logic clk = 0, rst, in_valid, in_ready, busy;
  logic [DW-1:0] in_data, y0, y1, y2, y3;
  logic [3:0] ch_en, out_valid, out_ready;
  logic [1:0] sel;
`ifdef DEMUX_DISPATCH_CNT_EN
  logic [4*CW-1:0] cnt_flat;
`endif

  demux_dispatcher #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ch_en(ch_en), .out_valid(out_valid), .out_ready(out_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .sel(sel), .busy(busy)
`ifdef DEMUX_DISPATCH_CNT_EN
    , .cnt_flat(cnt_flat)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0, failed = 0;
  bit m_full;
  int m_tgt, m_ptr, m_data;
  int m_cnt [4];

  function automatic int rr_next(int p, logic [3:0] en);
    for (int k = 1; k <= 4; k++) if (en[(p + k) % 4]) return (p + k) % 4;
    return p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_tgt = 0; m_ptr = 3; m_data = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic cycle(input logic r, input logic v, input logic [DW-1:0] d,
                       input logic [3:0] en, input logic [3:0] rdy);
    logic exp_rdy;
    bit acc, xfer;
    logic [15:0] lanes;
    rst = r; in_valid = v; in_data = d; ch_en = en; out_ready = rdy;
    #1;
    exp_rdy = !r && (en != 0) && (!m_full || rdy[m_tgt]);
    lanes = m_full ? 16'(m_data) << (4 * m_tgt) : 16'h0;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), m_full ? 32'(1) << m_tgt : 32'h0);
    chk("lanes", 32'({y3, y2, y1, y0}), 32'(lanes));
    chk("sel", 32'(sel), m_tgt);
    chk("busy", 32'(busy), 32'(m_full));
`ifdef DEMUX_DISPATCH_CNT_EN
    for (int i = 0; i < 4; i++) chk("cnt", 32'(cnt_flat[i*CW +: CW]), m_cnt[i]);
`endif
    acc = v && exp_rdy;
    xfer = m_full && rdy[m_tgt];
    @(posedge clk);
    if (r) model_reset();
    else begin
      if (xfer && m_cnt[m_tgt] < (1 << CW) - 1) m_cnt[m_tgt]++;
      if (acc) begin
        m_ptr = rr_next(m_ptr, en);
        m_tgt = m_ptr;
        m_data = int'(d);
        m_full = 1;
      end else if (xfer) m_full = 0;
    end
    @(negedge clk);
  endtask

  int exp_ch [3] = '{1, 3, 1};

  initial begin
    rst = 1; in_valid = 0; in_data = 0; ch_en = 4'hF; out_ready = 4'hF;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    cycle(1, 0, 0, 4'hF, 4'hF);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_valid", 32'(out_valid), 0);
    // round robin over all four lanes, full throughput
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, DW'(i + 1), 4'hF, 4'hF);
      chk("rr_valid", 32'(out_valid), 32'(1) << (i % 4));
      chk("rr_lanes", 32'({y3, y2, y1, y0}), 32'(i + 1) << (4 * (i % 4)));
    end
    cycle(0, 0, 0, 4'hF, 4'hF);
    // skip disabled lanes
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, DW'(4'hA + i), 4'b1010, 4'hF);
      chk("skip_valid", 32'(out_valid), 32'(1) << exp_ch[i]);
    end
    cycle(0, 0, 0, 4'b1010, 4'hF);
    // stall then pass-through without a bubble
    cycle(0, 1, 4'h7, 4'b0001, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 4'h9, 4'hF, 4'b0000);
      chk("stall_y0", 32'(y0), 7);
    end
    cycle(0, 1, 4'h8, 4'hF, 4'b0001);
    chk("pass_valid", 32'(out_valid), 32'b0010);
    chk("pass_y1", 32'(y1), 8);
    cycle(0, 0, 0, 4'hF, 4'hF);
    // mask change while full keeps the buffered target
    cycle(0, 1, 4'h3, 4'b0100, 4'b0000);
    cycle(0, 0, 0, 4'b0001, 4'b0000);
    chk("remask_valid", 32'(out_valid), 32'b0100);
    cycle(0, 1, 4'h6, 4'b0000, 4'b0000);
    chk("mask0_hold", 32'(y2), 3);
    cycle(0, 0, 0, 4'b0001, 4'hF);
    cycle(0, 1, 4'h6, 4'b0001, 4'hF);
    chk("remask_next", 32'(out_valid), 32'b0001);
    cycle(0, 0, 0, 4'hF, 4'hF);
    // reset mid-operation
    cycle(0, 1, 4'h5, 4'b0010, 4'b0000);
    chk("pre_rst_y1", 32'(y1), 5);
    cycle(1, 0, 0, 4'hF, 4'b0000);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_lanes", 32'({y3, y2, y1, y0}), 0);
    cycle(0, 1, 4'h4, 4'hF, 4'hF);
    chk("rst_first", 32'(out_valid), 32'b0001);
`ifdef DEMUX_DISPATCH_CNT_EN
    cycle(1, 0, 0, 4'hF, 4'hF);
    for (int i = 0; i < 5; i++) cycle(0, 1, DW'(i), 4'b0001, 4'hF);
    cycle(0, 0, 0, 4'b0001, 4'hF);
    chk("cnt_sat0", 32'(cnt_flat[CW-1:0]), 3);
    chk("cnt_others", 32'(cnt_flat[4*CW-1:CW]), 0);
`endif
    // random traffic
    for (int n = 0; n < 400; n++)
      cycle($urandom_range(0, 39) == 0, 1'($urandom), DW'($urandom), 4'($urandom), 4'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
